hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

- Issues pipeline stalls, bubbles and flushes for the 5-stage MIPS core.
- Complements forwarding: it covers the hazards that forwarding cannot resolve.
  - Load-use dependencies get a one-cycle front-end stall.
  - Taken branches/jumps resolved in EX get a wrong-path flush.
  - Multi-cycle multiply/divide holds EX for a fixed latency.
- Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
- Keeps a saturating count of stall cycles for performance measurement.

## Interface
Parameters:
- MULDIV_LATENCY, 4: cycles a mult/div instruction occupies EX; legal range 2..15.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- IF_ID_Rs  in  5  source register of the instruction in ID
- IF_ID_Rt  in  5  second register field of the instruction in ID
- IF_ID_UsesRt  in  1  the ID instruction reads Rt as a source
- ID_EX_Rt  in  5  destination of the instruction in EX, for loads
- ID_EX_MemRead  in  1  the EX instruction is a load
- ID_EX_MulDiv  in  1  the EX instruction is mult/multu/div/divu
- EX_BranchTaken  in  1  the EX branch/jump resolved taken this cycle
- PCWrite  out  1  PC may update
- IF_ID_Write  out  1  IF/ID may load
- IF_ID_Flush  out  1  clear IF/ID to a NOP
- ID_EX_Bubble  out  1  zero the ID/EX control fields
- EX_Hold  out  1  freeze ID/EX; EX re-executes
- EX_MEM_Bubble  out  1  zero the EX/MEM control fields
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with PCWrite=0

## Operation
FSM states, kept in a registered state plus a 4-bit down-counter `cnt`:
- RUN: normal operation.
- MD_BUSY: the mult/div in EX is still executing.
- MD_LAST: the final EX cycle of the mult/div.

Default outputs: PCWrite=1, IF_ID_Write=1; all other control outputs 0.

Rules in RUN and MD_LAST, evaluated in this priority order (first match wins):
1. Branch flush.
   - Condition: EX_BranchTaken=1.
   - Outputs: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
   - Load-use detection is suppressed, because the dependent instruction is squashed.
2. Mult/div start.
   - Condition: state is RUN and ID_EX_MulDiv=1.
   - Outputs: PCWrite=0, IF_ID_Write=0, EX_Hold=1, EX_MEM_Bubble=1, ID_EX_Bubble=0.
   - Next state: MD_LAST if MULDIV_LATENCY=2; otherwise MD_BUSY with cnt←MULDIV_LATENCY−2.
3. Load-use stall.
   - Condition: ID_EX_MemRead=1, ID_EX_Rt≠0, and either ID_EX_Rt==IF_ID_Rs, or IF_ID_UsesRt=1 and ID_EX_Rt==IF_ID_Rt.
   - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.

Behaviour in MD_BUSY:
- Outputs are the same as rule 2 every cycle.
- EX_BranchTaken, ID_EX_MulDiv and the load-use inputs are ignored.
- cnt decrements each cycle; when cnt==1 the next state is MD_LAST.

Behaviour in MD_LAST:
- No hold is asserted.
- ID_EX_MulDiv is ignored, since it is still the same instruction leaving EX; this blocks re-triggering.
- Rules 1 and 3 apply; next state is RUN.

Register 0 never causes a load-use stall.

stall_cycles:
- Increments by 1 on every non-reset cycle with PCWrite=0.
- Holds at all-ones once saturated.

## Timing
- Outputs are combinational from the current state and inputs; they are valid in the same cycle as the inputs.
- State, cnt and stall_cycles update on the rising edge of clk.
- Reset:
  - While reset=1, outputs take the defaults (PCWrite=1, IF_ID_Write=1, rest 0).
  - On the clock edge with reset=1: state←RUN, cnt←0, stall_cycles←0.
  - Reset asserted mid-MD_BUSY aborts the hold on the next edge.
- Load-use stall: exactly 1 cycle.
  - In the following cycle the load sits in MEM, so the hazard clears and forwarding supplies the value.
- Mult/div:
  - The instruction occupies EX for exactly MULDIV_LATENCY cycles.
  - EX_Hold is high for the first MULDIV_LATENCY−1 of those cycles and low in MD_LAST.
- A branch flush costs 1 cycle and asserts no stall.

## Structure
Shared package `mips_pkg` holds:
- the `hz_state_t` enum (RUN, MD_BUSY, MD_LAST);
- `REG_ZERO` = 5'd0;
- the `MULDIV_LAT_MAX` constant = 15.

One natural sub-module, `muldiv_hold_timer`, owns cnt and the MD_BUSY→MD_LAST decision. The FSM's priority logic and stall_cycles stay in the top level.

## Test plan
- Load-use:
  - Stimulus: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8.
  - Required: for one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles goes 0→1.
  - Repeat with ID_EX_Rt=0: no stall.
- Rt dependency:
  - IF_ID_Rt=9=ID_EX_Rt with IF_ID_UsesRt=1: stall.
  - Same case with IF_ID_UsesRt=0: no stall.
- Branch plus load-use in the same cycle:
  - Required: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; stall_cycles unchanged.
- Mult/div, MULDIV_LATENCY=4, ID_EX_MulDiv held high throughout:
  - Required: EX_Hold=1 for exactly 3 cycles, then 0.
  - No re-trigger in MD_LAST; stall_cycles increases by 3.
  - Repeat with MULDIV_LATENCY=2: exactly 1 hold cycle.
- Reset on the 2nd MD_BUSY cycle:
  - Required: the next cycle is in RUN with default outputs and stall_cycles=0.
- Saturation:
  - Stimulus: STALL_CNT_W=4 with a continuous mult/div stream.
  - Required: stall_cycles stops at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
package mips_pkg;

    // Hazard FSM states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_LAST = 2'd2
    } hz_state_t;

    // Architectural zero register; never a real data dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Longest supported mult/div occupancy of EX, in cycles.
    localparam int MULDIV_LAT_MAX = 15;

    // Width of the mult/div hold down-counter.
    localparam int MD_CNT_W = $clog2(MULDIV_LAT_MAX + 1);

endpackage

// File: rtl/muldiv_hold_timer.sv
// Down-counter that times how long a mult/div keeps EX held.
// Loaded when the mult/div starts, counts down while the FSM is busy and
// flags the cycle after which the FSM moves to its final EX cycle.
module muldiv_hold_timer
    import mips_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic expire
);

    // First cycle is spent in RUN and the last in MD_LAST, so the busy
    // phase lasts MULDIV_LATENCY-2 cycles.
    localparam logic [MD_CNT_W-1:0] LOAD_VALUE = MD_CNT_W'(MULDIV_LATENCY - 2);

    logic [MD_CNT_W-1:0] cnt_reg;

    // Load on start, then count down while the hold is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= LOAD_VALUE;
        end else if (busy && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expire = (cnt_reg == MD_CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard stall unit for the 5-stage MIPS core: load-use stalls, taken
// branch flushes and multi-cycle mult/div holds, plus a saturating count
// of cycles in which the PC was frozen.
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             IF_ID_Rs,
    input  logic [4:0]             IF_ID_Rt,
    input  logic                   IF_ID_UsesRt,
    input  logic [4:0]             ID_EX_Rt,
    input  logic                   ID_EX_MemRead,
    input  logic                   ID_EX_MulDiv,
    input  logic                   EX_BranchTaken,
    output logic                   PCWrite,
    output logic                   IF_ID_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Bubble,
    output logic                   EX_Hold,
    output logic                   EX_MEM_Bubble,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    hz_state_t state_reg;
    hz_state_t state_next;

    logic md_start;
    logic md_busy;
    logic md_expire;
    logic load_use;

    logic [STALL_CNT_W-1:0] stall_cycles_reg;

    // A load in EX feeding the ID instruction; r0 is never a dependency.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt != REG_ZERO) &&
                      ((ID_EX_Rt == IF_ID_Rs) ||
                       (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

    muldiv_hold_timer #(
        .MULDIV_LATENCY(MULDIV_LATENCY)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .busy   (md_busy),
        .expire (md_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Priority hazard resolution and next-state logic; defaults while in reset.
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        EX_Hold       = 1'b0;
        EX_MEM_Bubble = 1'b0;
        md_start      = 1'b0;
        md_busy       = 1'b0;
        state_next    = state_reg;

        if (!reset) begin
            case (state_reg)
                MD_BUSY: begin
                    // Mult/div still executing: everything else waits.
                    PCWrite       = 1'b0;
                    IF_ID_Write   = 1'b0;
                    EX_Hold       = 1'b1;
                    EX_MEM_Bubble = 1'b1;
                    md_busy       = 1'b1;
                    state_next    = md_expire ? MD_LAST : MD_BUSY;
                end
                default: begin
                    // RUN and MD_LAST; in MD_LAST the MulDiv flag belongs to
                    // the instruction now leaving EX and must not restart it.
                    state_next = RUN;
                    if (EX_BranchTaken) begin
                        // The dependent instruction is squashed, so no stall.
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if ((state_reg == RUN) && ID_EX_MulDiv) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        EX_Hold       = 1'b1;
                        EX_MEM_Bubble = 1'b1;
                        md_start      = 1'b1;
                        state_next    = (MULDIV_LATENCY == 2) ? MD_LAST : MD_BUSY;
                    end else if (load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles with the PC frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (!PCWrite && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit. Three instances share the same
// stimulus: latency 4 / 16-bit counter, latency 2 / 16-bit counter and
// latency 4 / 4-bit counter for saturation. Expected control vectors are
// pushed with each stimulus and compared at the following falling edge.
module tb_hazard_stall_unit;

    // Control vector order: {PCWrite, IF_ID_Write, IF_ID_Flush,
    //                        ID_EX_Bubble, EX_Hold, EX_MEM_Bubble}
    localparam logic [5:0] C_DEF   = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_FLUSH = 6'b111100;
    localparam logic [5:0] C_HOLD  = 6'b000011;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic       mem_read;
        logic       mul_div;
        logic       branch;
        logic       rst;
    } stim_t;

    typedef struct {
        string      tag;
        logic [5:0] c4;
        logic [5:0] c2;
        int         sc4;
        int         sc2;
        int         scs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] if_id_rs = '0;
    logic [4:0] if_id_rt = '0;
    logic if_id_uses_rt = 1'b0;
    logic [4:0] id_ex_rt = '0;
    logic id_ex_mem_read = 1'b0;
    logic id_ex_mul_div = 1'b0;
    logic ex_branch_taken = 1'b0;

    logic [5:0]  ctl4, ctl2, ctls;
    logic [15:0] sc4_out, sc2_out;
    logic [3:0]  scs_out;

    int total = 0;
    int bad = 0;
    int exp_sc4 = 0;
    int exp_sc2 = 0;
    int exp_scs = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(.MULDIV_LATENCY(4), .STALL_CNT_W(16)) dut4 (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt), .IF_ID_UsesRt(if_id_uses_rt),
        .ID_EX_Rt(id_ex_rt), .ID_EX_MemRead(id_ex_mem_read),
        .ID_EX_MulDiv(id_ex_mul_div), .EX_BranchTaken(ex_branch_taken),
        .PCWrite(ctl4[5]), .IF_ID_Write(ctl4[4]), .IF_ID_Flush(ctl4[3]),
        .ID_EX_Bubble(ctl4[2]), .EX_Hold(ctl4[1]), .EX_MEM_Bubble(ctl4[0]),
        .stall_cycles(sc4_out)
    );

    hazard_stall_unit #(.MULDIV_LATENCY(2), .STALL_CNT_W(16)) dut2 (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt), .IF_ID_UsesRt(if_id_uses_rt),
        .ID_EX_Rt(id_ex_rt), .ID_EX_MemRead(id_ex_mem_read),
        .ID_EX_MulDiv(id_ex_mul_div), .EX_BranchTaken(ex_branch_taken),
        .PCWrite(ctl2[5]), .IF_ID_Write(ctl2[4]), .IF_ID_Flush(ctl2[3]),
        .ID_EX_Bubble(ctl2[2]), .EX_Hold(ctl2[1]), .EX_MEM_Bubble(ctl2[0]),
        .stall_cycles(sc2_out)
    );

    hazard_stall_unit #(.MULDIV_LATENCY(4), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt), .IF_ID_UsesRt(if_id_uses_rt),
        .ID_EX_Rt(id_ex_rt), .ID_EX_MemRead(id_ex_mem_read),
        .ID_EX_MulDiv(id_ex_mul_div), .EX_BranchTaken(ex_branch_taken),
        .PCWrite(ctls[5]), .IF_ID_Write(ctls[4]), .IF_ID_Flush(ctls[3]),
        .ID_EX_Bubble(ctls[2]), .EX_Hold(ctls[1]), .EX_MEM_Bubble(ctls[0]),
        .stall_cycles(scs_out)
    );

    task automatic check_val(input string tag, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    function automatic stim_t mk(input int rs, input int rt, input int uses_rt,
                                 input int ex_rt, input int mem_read,
                                 input int mul_div, input int branch,
                                 input int rst);
        stim_t s;
        s.rs       = 5'(rs);
        s.rt       = 5'(rt);
        s.uses_rt  = 1'(uses_rt);
        s.ex_rt    = 5'(ex_rt);
        s.mem_read = 1'(mem_read);
        s.mul_div  = 1'(mul_div);
        s.branch   = 1'(branch);
        s.rst      = 1'(rst);
        return s;
    endfunction

    // Drive one cycle of stimulus and queue what each instance must show.
    task automatic step(input string tag, input stim_t s,
                        input logic [5:0] e4, input logic [5:0] e2);
        exp_t e;
        @(posedge clk);
        #1;
        if_id_rs        = s.rs;
        if_id_rt        = s.rt;
        if_id_uses_rt   = s.uses_rt;
        id_ex_rt        = s.ex_rt;
        id_ex_mem_read  = s.mem_read;
        id_ex_mul_div   = s.mul_div;
        ex_branch_taken = s.branch;
        reset           = s.rst;
        e.tag = tag;
        e.c4  = e4;
        e.c2  = e2;
        e.sc4 = exp_sc4;
        e.sc2 = exp_sc2;
        e.scs = exp_scs;
        sbq.push_back(e);
        // Counter values that the next edge must produce.
        if (s.rst) begin
            exp_sc4 = 0;
            exp_sc2 = 0;
            exp_scs = 0;
        end else begin
            if (!e4[5]) exp_sc4++;
            if (!e2[5]) exp_sc2++;
            if (!e4[5] && exp_scs < 15) exp_scs++;
        end
    endtask

    // Compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val({e.tag, " ctl4"}, int'(ctl4), int'(e.c4));
            check_val({e.tag, " ctl2"}, int'(ctl2), int'(e.c2));
            check_val({e.tag, " ctls"}, int'(ctls), int'(e.c4));
            check_val({e.tag, " sc4"}, int'(sc4_out), e.sc4);
            check_val({e.tag, " sc2"}, int'(sc2_out), e.sc2);
            check_val({e.tag, " scs"}, int'(scs_out), e.scs);
            $display("cycle %s ctl4=%b ctl2=%b sc4=%0d sc2=%0d scs=%0d",
                     e.tag, ctl4, ctl2, sc4_out, sc2_out, scs_out);
        end
    end

    initial begin
        // Reset: outputs stay at defaults even with hazards presented.
        step("rst_md",    mk(8, 0, 0, 8, 1, 1, 0, 1), C_DEF, C_DEF);
        step("rst_idle",  mk(0, 0, 0, 0, 0, 0, 0, 1), C_DEF, C_DEF);
        step("idle0",     mk(0, 0, 0, 0, 0, 0, 0, 0), C_DEF, C_DEF);
        // Load-use on Rs, then clears the next cycle.
        step("lu_rs",     mk(8, 0, 0, 8, 1, 0, 0, 0), C_STALL, C_STALL);
        step("lu_after",  mk(8, 0, 0, 8, 0, 0, 0, 0), C_DEF, C_DEF);
        step("lu_r0",     mk(0, 0, 1, 0, 1, 0, 0, 0), C_DEF, C_DEF);
        // Rt dependency with and without UsesRt.
        step("lu_rt",     mk(3, 9, 1, 9, 1, 0, 0, 0), C_STALL, C_STALL);
        step("lu_rt_nu",  mk(3, 9, 0, 9, 1, 0, 0, 0), C_DEF, C_DEF);
        // Branch beats load-use.
        step("br_lu",     mk(8, 0, 0, 8, 1, 0, 1, 0), C_FLUSH, C_FLUSH);
        step("idle1",     mk(0, 0, 0, 0, 0, 0, 0, 0), C_DEF, C_DEF);
        // Mult/div held high four cycles; branch in cycle 2 is ignored by
        // the busy latency-4 unit but flushes in the latency-2 MD_LAST.
        step("md0",       mk(0, 0, 0, 0, 0, 1, 0, 0), C_HOLD, C_HOLD);
        step("md1",       mk(0, 0, 0, 0, 0, 1, 1, 0), C_HOLD, C_FLUSH);
        step("md2",       mk(0, 0, 0, 0, 0, 1, 0, 0), C_HOLD, C_HOLD);
        step("md3",       mk(0, 0, 0, 0, 0, 1, 0, 0), C_DEF,  C_DEF);
        // Load-use still applies in MD_LAST.
        step("md_a",      mk(0, 0, 0, 0, 0, 1, 0, 0), C_HOLD, C_HOLD);
        step("md_b",      mk(5, 0, 0, 5, 1, 0, 0, 0), C_HOLD, C_STALL);
        step("md_c",      mk(5, 0, 0, 5, 1, 0, 0, 0), C_HOLD, C_STALL);
        step("md_d",      mk(5, 0, 0, 5, 1, 0, 0, 0), C_STALL, C_STALL);
        step("idle2",     mk(0, 0, 0, 0, 0, 0, 0, 0), C_DEF, C_DEF);
        // Reset on the second MD_BUSY cycle aborts the hold.
        step("mr_start",  mk(0, 0, 0, 0, 0, 1, 0, 0), C_HOLD, C_HOLD);
        step("mr_busy1",  mk(0, 0, 0, 0, 0, 0, 0, 0), C_HOLD, C_DEF);
        step("mr_rst",    mk(0, 0, 0, 0, 0, 0, 0, 1), C_DEF,  C_DEF);
        step("mr_after",  mk(0, 0, 0, 0, 0, 0, 0, 0), C_DEF,  C_DEF);
        step("mr_lu",     mk(7, 0, 0, 7, 1, 0, 0, 0), C_STALL, C_STALL);
        // Continuous mult/div stream: 4-bit counter saturates at 15.
        for (int i = 0; i < 40; i++) begin
            step($sformatf("stream%0d", i), mk(0, 0, 0, 0, 0, 1, 0, 0),
                 (i % 4 == 3) ? C_DEF : C_HOLD,
                 (i % 2 == 1) ? C_DEF : C_HOLD);
        end
        step("end_idle",  mk(0, 0, 0, 0, 0, 0, 0, 0), C_DEF, C_DEF);
        step("end_idle2", mk(0, 0, 0, 0, 0, 0, 0, 0), C_DEF, C_DEF);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        check_val("drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
